// File: rtl/lap_record_pkg_57.sv
// Shared types and constants for the lap/snapshot record controller.
package lap_record_pkg_57;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RD_ISSUE,
        ST_RD_WAIT
    } state_t;

    localparam int         TIME_W   = 21;
    localparam logic [2:0] SLOT_CLK = 3'd0;

    localparam int SEC_LSB  = 0;
    localparam int SEC_MSB  = 6;
    localparam int MIN_LSB  = 7;
    localparam int MIN_MSB  = 13;
    localparam int HOUR_LSB = 14;
    localparam int HOUR_MSB = 20;

endpackage

// File: rtl/lap_record_ctrl_57_view_nav.sv
// Browse pointer wrap: next/prev over slot 0 and lap slots 1..lap_count.
module view_nav_57
    import lap_record_pkg_57::*;
(
    input  logic [2:0] cur_addr,
    input  logic [2:0] lap_count,
    input  logic       next,
    input  logic       prev,
    output logic [2:0] new_addr,
    output logic       move
);

    always_comb begin
        new_addr = cur_addr;
        move     = next ^ prev;
        if (next && !prev) begin
            new_addr = (cur_addr >= lap_count) ? 3'd0 : cur_addr + 3'd1;
        end else if (prev && !next) begin
            new_addr = (cur_addr == 3'd0) ? lap_count : cur_addr - 3'd1;
        end
    end

endmodule

// File: rtl/lap_record_ctrl_57.sv
// Register-file arbiter for lap capture, clock snapshot and display browse.
// Define LAP_OVERWRITE_EN to let laps overwrite the oldest slot when full.
module lap_record_ctrl_57 #(
    parameter int         N_LAP    = 6,
    parameter logic [2:0] SLOT_CLK = lap_record_pkg_57::SLOT_CLK
) (
    input  logic        clk_57,
    input  logic        rst_n_57,
    input  logic        lap_req_57,
    input  logic [20:0] lap_time_57,
    input  logic        save_req_57,
    input  logic [20:0] clk_time_57,
    input  logic        view_next_57,
    input  logic        view_prev_57,
    input  logic        clear_laps_57,
    output logic        reg_write_e_57,
    output logic [2:0]  reg_write_addr_57,
    output logic [20:0] reg_wdata_57,
    output logic        reg_read_e_57,
    output logic [2:0]  reg_read_addr_57,
    input  logic [20:0] reg_rdata_57,
    output logic [2:0]  view_addr_57,
    output logic [20:0] view_time_57,
    output logic        view_valid_57,
    output logic [2:0]  lap_count_57,
    output logic        lap_full_57,
    output logic        busy_57
);
    import lap_record_pkg_57::*;

    localparam logic [2:0] LAP_MAX = 3'(N_LAP);

    state_t      state_q, state_d;
    logic        lap_pend_q, lap_pend_d;
    logic        save_pend_q, save_pend_d;
    logic        view_pend_q, view_pend_d;
    logic        clr_pend_q, clr_pend_d;
    logic        wr_lap_q, wr_lap_d;
    logic [2:0]  wr_addr_q, wr_addr_d;
    logic [2:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]  lap_count_q, lap_count_d;
    logic [2:0]  view_addr_q, view_addr_d;
    logic        view_valid_q, view_valid_d;
    logic [20:0] lap_data_q, lap_data_d;
    logic [20:0] save_data_q, save_data_d;
    logic [20:0] wr_data_q, wr_data_d;
    logic [20:0] view_time_q, view_time_d;

    logic [2:0]  nav_addr;
    logic        nav_move;
    logic        lap_block;
    logic        in_lap_wr;
    logic        clr_now;
    logic        lap_acc;

    view_nav_57 u_nav (
        .cur_addr  (view_addr_q),
        .lap_count (lap_count_q),
        .next      (view_next_57),
        .prev      (view_prev_57),
        .new_addr  (nav_addr),
        .move      (nav_move)
    );

`ifdef LAP_OVERWRITE_EN
    assign lap_block = 1'b0;
`else
    assign lap_block = lap_full_57;
`endif

    always_comb begin
        state_d      = state_q;
        lap_pend_d   = lap_pend_q;
        save_pend_d  = save_pend_q;
        view_pend_d  = view_pend_q;
        wr_lap_d     = wr_lap_q;
        wr_addr_d    = wr_addr_q;
        wr_ptr_d     = wr_ptr_q;
        lap_count_d  = lap_count_q;
        view_addr_d  = view_addr_q;
        view_valid_d = view_valid_q;
        lap_data_d   = lap_data_q;
        save_data_d  = save_data_q;
        wr_data_d    = wr_data_q;
        view_time_d  = view_time_q;

        // A clear arriving during a lap write is deferred by one cycle
        in_lap_wr  = (state_q == ST_WRITE) && wr_lap_q;
        clr_now    = (clear_laps_57 && !in_lap_wr) || clr_pend_q;
        clr_pend_d = clear_laps_57 && in_lap_wr;
        lap_acc    = lap_req_57 && !clear_laps_57 && !lap_block;

        unique case (state_q)
            ST_IDLE: begin
                if (lap_pend_q && lap_block) begin
                    lap_pend_d = 1'b0;
                end
                if (lap_pend_q && !clr_now && !lap_block) begin
                    state_d    = ST_WRITE;
                    wr_lap_d   = 1'b1;
                    wr_addr_d  = wr_ptr_q;
                    wr_data_d  = lap_data_q;
                    lap_pend_d = 1'b0;
                end else if (save_pend_q) begin
                    state_d     = ST_WRITE;
                    wr_lap_d    = 1'b0;
                    wr_addr_d   = SLOT_CLK;
                    wr_data_d   = save_data_q;
                    save_pend_d = 1'b0;
                end else if (view_pend_q) begin
                    state_d = ST_RD_ISSUE;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
                if (wr_lap_q) begin
                    wr_ptr_d     = (wr_ptr_q == LAP_MAX) ? 3'd1
                                 : wr_ptr_q + 3'd1;
                    lap_count_d  = (lap_count_q == LAP_MAX) ? lap_count_q
                                 : lap_count_q + 3'd1;
                    view_addr_d  = wr_addr_q;
                    view_pend_d  = 1'b1;
                    view_valid_d = 1'b0;
                end else if (view_addr_q == wr_addr_q) begin
                    view_pend_d  = 1'b1;
                    view_valid_d = 1'b0;
                end
            end
            ST_RD_ISSUE: begin
                state_d     = ST_RD_WAIT;
                view_pend_d = 1'b0;
            end
            ST_RD_WAIT: begin
                state_d      = ST_IDLE;
                view_time_d  = reg_rdata_57;
                view_valid_d = !view_pend_q;
            end
        endcase

        if (nav_move) begin
            view_addr_d  = nav_addr;
            view_pend_d  = 1'b1;
            view_valid_d = 1'b0;
        end

        if (clr_now) begin
            lap_count_d  = 3'd0;
            wr_ptr_d     = 3'd1;
            view_addr_d  = 3'd0;
            view_pend_d  = 1'b1;
            view_valid_d = 1'b0;
            lap_pend_d   = 1'b0;
        end

        // Latched data is last-wins; the write copy was taken above
        if (lap_acc) begin
            lap_pend_d = 1'b1;
            lap_data_d = lap_time_57;
        end
        if (save_req_57) begin
            save_pend_d = 1'b1;
            save_data_d = clk_time_57;
        end
    end

    always_ff @(posedge clk_57 or negedge rst_n_57) begin
        if (!rst_n_57) begin
            state_q      <= ST_IDLE;
            lap_pend_q   <= 1'b0;
            save_pend_q  <= 1'b0;
            view_pend_q  <= 1'b0;
            clr_pend_q   <= 1'b0;
            wr_lap_q     <= 1'b0;
            wr_addr_q    <= 3'd0;
            wr_ptr_q     <= 3'd1;
            lap_count_q  <= 3'd0;
            view_addr_q  <= 3'd0;
            view_valid_q <= 1'b0;
            lap_data_q   <= '0;
            save_data_q  <= '0;
            wr_data_q    <= '0;
            view_time_q  <= '0;
        end else begin
            state_q      <= state_d;
            lap_pend_q   <= lap_pend_d;
            save_pend_q  <= save_pend_d;
            view_pend_q  <= view_pend_d;
            clr_pend_q   <= clr_pend_d;
            wr_lap_q     <= wr_lap_d;
            wr_addr_q    <= wr_addr_d;
            wr_ptr_q     <= wr_ptr_d;
            lap_count_q  <= lap_count_d;
            view_addr_q  <= view_addr_d;
            view_valid_q <= view_valid_d;
            lap_data_q   <= lap_data_d;
            save_data_q  <= save_data_d;
            wr_data_q    <= wr_data_d;
            view_time_q  <= view_time_d;
        end
    end

    assign reg_write_e_57    = (state_q == ST_WRITE);
    assign reg_write_addr_57 = reg_write_e_57 ? wr_addr_q : 3'd0;
    assign reg_wdata_57      = reg_write_e_57 ? wr_data_q : '0;
    assign reg_read_e_57     = (state_q == ST_RD_ISSUE);
    assign reg_read_addr_57  = reg_read_e_57 ? view_addr_q : 3'd0;
    assign view_addr_57      = view_addr_q;
    assign view_time_57      = view_time_q;
    assign view_valid_57     = view_valid_q;
    assign lap_count_57      = lap_count_q;
    assign lap_full_57       = (lap_count_q == LAP_MAX);
    assign busy_57           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lap_record_ctrl_57.sv
// Directed bench for lap_record_ctrl_57 with a behavioural register file.
module tb_lap_record_ctrl_57;

    logic        clk_57 = 1'b0;
    logic        rst_n_57 = 1'b1;
    logic        lap_req_57 = 1'b0;
    logic [20:0] lap_time_57 = '0;
    logic        save_req_57 = 1'b0;
    logic [20:0] clk_time_57 = '0;
    logic        view_next_57 = 1'b0;
    logic        view_prev_57 = 1'b0;
    logic        clear_laps_57 = 1'b0;
    logic        reg_write_e_57;
    logic [2:0]  reg_write_addr_57;
    logic [20:0] reg_wdata_57;
    logic        reg_read_e_57;
    logic [2:0]  reg_read_addr_57;
    logic [20:0] reg_rdata_57;
    logic [2:0]  view_addr_57;
    logic [20:0] view_time_57;
    logic        view_valid_57;
    logic [2:0]  lap_count_57;
    logic        lap_full_57;
    logic        busy_57;

    int n_run = 0;
    int n_fail = 0;

    logic [20:0] mem [0:7] = '{default: '0};
    logic [20:0] rdata_q = '0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          ovl_cnt = 0;
    logic [2:0]  last_wa = '0;
    logic [20:0] last_wd = '0;

    lap_record_ctrl_57 dut (
        .clk_57            (clk_57),
        .rst_n_57          (rst_n_57),
        .lap_req_57        (lap_req_57),
        .lap_time_57       (lap_time_57),
        .save_req_57       (save_req_57),
        .clk_time_57       (clk_time_57),
        .view_next_57      (view_next_57),
        .view_prev_57      (view_prev_57),
        .clear_laps_57     (clear_laps_57),
        .reg_write_e_57    (reg_write_e_57),
        .reg_write_addr_57 (reg_write_addr_57),
        .reg_wdata_57      (reg_wdata_57),
        .reg_read_e_57     (reg_read_e_57),
        .reg_read_addr_57  (reg_read_addr_57),
        .reg_rdata_57      (reg_rdata_57),
        .view_addr_57      (view_addr_57),
        .view_time_57      (view_time_57),
        .view_valid_57     (view_valid_57),
        .lap_count_57      (lap_count_57),
        .lap_full_57       (lap_full_57),
        .busy_57           (busy_57)
    );

    always #5 clk_57 = ~clk_57;

    assign reg_rdata_57 = rdata_q;

    always @(posedge clk_57) begin
        if (reg_write_e_57) begin
            mem[reg_write_addr_57] <= reg_wdata_57;
            wr_cnt  <= wr_cnt + 1;
            last_wa <= reg_write_addr_57;
            last_wd <= reg_wdata_57;
        end
        if (reg_read_e_57) begin
            rdata_q <= mem[reg_read_addr_57];
            rd_cnt  <= rd_cnt + 1;
        end
        if (reg_write_e_57 && reg_read_e_57) begin
            ovl_cnt <= ovl_cnt + 1;
        end
    end

    function automatic logic [20:0] hms(input int h, input int m, input int s);
        return {7'(h), 7'(m), 7'(s)};
    endfunction

    task automatic tick();
        @(posedge clk_57);
        #1;
    endtask

    task automatic do_lap(input logic [20:0] t);
        lap_req_57  = 1'b1;
        lap_time_57 = t;
        tick();
        lap_req_57 = 1'b0;
        repeat (6) tick();
    endtask

    task automatic do_clear();
        clear_laps_57 = 1'b1;
        tick();
        clear_laps_57 = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        #2 rst_n_57 = 1'b0;
        #1;
        n_run++;
        if (busy_57 !== 1'b0 || reg_write_e_57 !== 1'b0 || reg_read_e_57 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: busy=%b we=%b re=%b want 0", busy_57, reg_write_e_57, reg_read_e_57);
        end
        n_run++;
        if (lap_count_57 !== 3'd0 || lap_full_57 !== 1'b0 || view_addr_57 !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: cnt=%0d full=%b va=%0d want 0", lap_count_57, lap_full_57, view_addr_57);
        end
        n_run++;
        if (view_valid_57 !== 1'b0 || view_time_57 !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_view: valid=%b time=%h want 0", view_valid_57, view_time_57);
        end
        repeat (2) tick();
        #3 rst_n_57 = 1'b1;
        repeat (3) tick();
        n_run++;
        if (busy_57 !== 1'b0 || wr_cnt != 0 || rd_cnt != 0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b wr=%0d rd=%0d want 0", busy_57, wr_cnt, rd_cnt);
        end
    endtask

    task automatic test_three_laps();
        logic [20:0] t [3];
        t[0] = hms(0, 0, 5);
        t[1] = hms(0, 0, 12);
        t[2] = hms(0, 1, 3);
        for (int i = 0; i < 3; i++) begin
            lap_req_57  = 1'b1;
            lap_time_57 = t[i];
            tick();
            lap_req_57 = 1'b0;
            n_run++;
            if (reg_write_e_57 !== 1'b0) begin
                n_fail++;
                $display("FAIL lap_early_write: we=%b want 0", reg_write_e_57);
            end
            tick();
            n_run++;
            if (reg_write_e_57 !== 1'b1 || reg_write_addr_57 !== 3'(i + 1) || reg_wdata_57 !== t[i]) begin
                n_fail++;
                $display("FAIL lap_write%0d: we=%b a=%0d d=%h want 1 %0d %h",
                         i, reg_write_e_57, reg_write_addr_57, reg_wdata_57, i + 1, t[i]);
            end
            repeat (5) tick();
        end
        n_run++;
        if (lap_count_57 !== 3'd3 || view_addr_57 !== 3'd3) begin
            n_fail++;
            $display("FAIL three_laps_cnt: cnt=%0d va=%0d want 3 3", lap_count_57, view_addr_57);
        end
        n_run++;
        if (view_valid_57 !== 1'b1 || view_time_57 !== t[2]) begin
            n_fail++;
            $display("FAIL three_laps_view: valid=%b time=%h want 1 %h", view_valid_57, view_time_57, t[2]);
        end
    endtask

    task automatic test_clear();
        int snap;
        do_lap(hms(0, 2, 0));
        n_run++;
        if (lap_count_57 !== 3'd4 || last_wa !== 3'd4) begin
            n_fail++;
            $display("FAIL clear_pre: cnt=%0d wa=%0d want 4 4", lap_count_57, last_wa);
        end
        snap = wr_cnt;
        clear_laps_57 = 1'b1;
        lap_req_57    = 1'b1;
        lap_time_57   = hms(0, 9, 9);
        tick();
        clear_laps_57 = 1'b0;
        lap_req_57    = 1'b0;
        n_run++;
        if (lap_count_57 !== 3'd0 || view_addr_57 !== 3'd0 || view_valid_57 !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_apply: cnt=%0d va=%0d valid=%b want 0 0 0", lap_count_57, view_addr_57, view_valid_57);
        end
        repeat (6) tick();
        n_run++;
        if (wr_cnt != snap) begin
            n_fail++;
            $display("FAIL clear_drops_lap: writes=%0d want %0d", wr_cnt, snap);
        end
        do_lap(hms(0, 3, 0));
        n_run++;
        if (last_wa !== 3'd1 || lap_count_57 !== 3'd1) begin
            n_fail++;
            $display("FAIL clear_next_lap: wa=%0d cnt=%0d want 1 1", last_wa, lap_count_57);
        end
        lap_req_57  = 1'b1;
        lap_time_57 = hms(0, 4, 0);
        tick();
        lap_req_57 = 1'b0;
        tick();
        n_run++;
        if (reg_write_e_57 !== 1'b1 || reg_write_addr_57 !== 3'd2) begin
            n_fail++;
            $display("FAIL clear_mid_write: we=%b a=%0d want 1 2", reg_write_e_57, reg_write_addr_57);
        end
        clear_laps_57 = 1'b1;
        tick();
        clear_laps_57 = 1'b0;
        n_run++;
        if (lap_count_57 !== 3'd2 || view_addr_57 !== 3'd2) begin
            n_fail++;
            $display("FAIL clear_defer: cnt=%0d va=%0d want 2 2", lap_count_57, view_addr_57);
        end
        tick();
        n_run++;
        if (lap_count_57 !== 3'd0 || view_addr_57 !== 3'd0) begin
            n_fail++;
            $display("FAIL clear_after_write: cnt=%0d va=%0d want 0 0", lap_count_57, view_addr_57);
        end
        repeat (6) tick();
    endtask

    task automatic test_full();
        int snap;
        logic [20:0] lap7;
        do_clear();
        for (int i = 1; i <= 6; i++) begin
            do_lap(hms(1, i, 0));
        end
        n_run++;
        if (lap_count_57 !== 3'd6 || lap_full_57 !== 1'b1 || last_wa !== 3'd6) begin
            n_fail++;
            $display("FAIL full_six: cnt=%0d full=%b wa=%0d want 6 1 6", lap_count_57, lap_full_57, last_wa);
        end
        snap = wr_cnt;
        lap7 = hms(1, 7, 7);
        do_lap(lap7);
        n_run++;
        if (lap_count_57 !== 3'd6 || lap_full_57 !== 1'b1) begin
            n_fail++;
            $display("FAIL full_seventh_cnt: cnt=%0d full=%b want 6 1", lap_count_57, lap_full_57);
        end
`ifdef LAP_OVERWRITE_EN
        n_run++;
        if (wr_cnt != snap + 1 || last_wa !== 3'd1 || mem[1] !== lap7) begin
            n_fail++;
            $display("FAIL full_overwrite: writes=%0d wa=%0d m1=%h want %0d 1 %h",
                     wr_cnt, last_wa, mem[1], snap + 1, lap7);
        end
`else
        n_run++;
        if (wr_cnt != snap || mem[1] !== hms(1, 1, 0)) begin
            n_fail++;
            $display("FAIL full_drop: writes=%0d m1=%h want %0d %h", wr_cnt, mem[1], snap, hms(1, 1, 0));
        end
`endif
    endtask

    task automatic test_save_lap_same();
        logic [20:0] l;
        logic [20:0] c;
        l = hms(0, 2, 30);
        c = hms(13, 45, 7);
        do_clear();
        lap_req_57  = 1'b1;
        lap_time_57 = l;
        save_req_57 = 1'b1;
        clk_time_57 = c;
        tick();
        lap_req_57  = 1'b0;
        save_req_57 = 1'b0;
        tick();
        n_run++;
        if (reg_write_e_57 !== 1'b1 || reg_write_addr_57 !== 3'd1 || reg_wdata_57 !== l) begin
            n_fail++;
            $display("FAIL same_lap_first: we=%b a=%0d d=%h want 1 1 %h", reg_write_e_57, reg_write_addr_57, reg_wdata_57, l);
        end
        tick();
        n_run++;
        if (reg_write_e_57 !== 1'b0) begin
            n_fail++;
            $display("FAIL same_gap: we=%b want 0", reg_write_e_57);
        end
        tick();
        n_run++;
        if (reg_write_e_57 !== 1'b1 || reg_write_addr_57 !== 3'd0 || reg_wdata_57 !== c) begin
            n_fail++;
            $display("FAIL same_save_second: we=%b a=%0d d=%h want 1 0 %h", reg_write_e_57, reg_write_addr_57, reg_wdata_57, c);
        end
        repeat (6) tick();
        n_run++;
        if (mem[1] !== l || mem[0] !== c || ovl_cnt != 0) begin
            n_fail++;
            $display("FAIL same_contents: m1=%h m0=%h ovl=%0d want %h %h 0", mem[1], mem[0], ovl_cnt, l, c);
        end
    endtask

    task automatic test_browse();
        logic        nxt [5];
        logic [2:0]  ea [5];
        logic [20:0] ed [5];
        logic [20:0] b;
        b = hms(0, 3, 1);
        do_lap(b);
        n_run++;
        if (lap_count_57 !== 3'd2 || view_addr_57 !== 3'd2) begin
            n_fail++;
            $display("FAIL browse_setup: cnt=%0d va=%0d want 2 2", lap_count_57, view_addr_57);
        end
        nxt = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ea  = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd2};
        ed  = '{hms(13, 45, 7), hms(0, 2, 30), b, hms(13, 45, 7), b};
        for (int i = 0; i < 5; i++) begin
            view_next_57 = nxt[i];
            view_prev_57 = !nxt[i];
            tick();
            view_next_57 = 1'b0;
            view_prev_57 = 1'b0;
            n_run++;
            if (view_addr_57 !== ea[i] || view_valid_57 !== 1'b0) begin
                n_fail++;
                $display("FAIL browse_addr%0d: va=%0d valid=%b want %0d 0", i, view_addr_57, view_valid_57, ea[i]);
            end
            repeat (3) tick();
            n_run++;
            if (view_valid_57 !== 1'b1 || view_time_57 !== ed[i]) begin
                n_fail++;
                $display("FAIL browse_data%0d: valid=%b time=%h want 1 %h", i, view_valid_57, view_time_57, ed[i]);
            end
            repeat (2) tick();
        end
        view_next_57 = 1'b1;
        view_prev_57 = 1'b1;
        tick();
        view_next_57 = 1'b0;
        view_prev_57 = 1'b0;
        n_run++;
        if (view_addr_57 !== 3'd2 || view_valid_57 !== 1'b1) begin
            n_fail++;
            $display("FAIL browse_both: va=%0d valid=%b want 2 1", view_addr_57, view_valid_57);
        end
        repeat (4) tick();
    endtask

    task automatic test_reset_rd_wait();
        int swr;
        int srd;
        view_next_57 = 1'b1;
        tick();
        view_next_57 = 1'b0;
        tick();
        n_run++;
        if (reg_read_e_57 !== 1'b1 || reg_read_addr_57 !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_rd_issue: re=%b a=%0d want 1 0", reg_read_e_57, reg_read_addr_57);
        end
        tick();
        n_run++;
        if (busy_57 !== 1'b1 || reg_read_e_57 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_rd_wait: busy=%b re=%b want 1 0", busy_57, reg_read_e_57);
        end
        #2 rst_n_57 = 1'b0;
        #1;
        n_run++;
        if (busy_57 !== 1'b0 || lap_count_57 !== 3'd0 || view_addr_57 !== 3'd0
            || view_valid_57 !== 1'b0 || view_time_57 !== 21'd0) begin
            n_fail++;
            $display("FAIL rst_async: busy=%b cnt=%0d va=%0d valid=%b time=%h want all 0",
                     busy_57, lap_count_57, view_addr_57, view_valid_57, view_time_57);
        end
        #2 rst_n_57 = 1'b1;
        swr = wr_cnt;
        srd = rd_cnt;
        repeat (6) tick();
        n_run++;
        if (wr_cnt != swr || rd_cnt != srd || busy_57 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_strobe: wr=%0d rd=%0d busy=%b want %0d %0d 0", wr_cnt, rd_cnt, busy_57, swr, srd);
        end
        n_run++;
        if (ovl_cnt != 0) begin
            n_fail++;
            $display("FAIL strobe_overlap: count=%0d want 0", ovl_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_three_laps();
        test_clear();
        test_full();
        test_save_lap_same();
        test_browse();
        test_reset_rd_wait();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
